// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types, constants and op-decode helpers for the RV32M multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} mdu_state_e;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q = 32'h8000_0000;
  function automatic logic is_div(mdu_op_e op);
    return op[2];
  endfunction
  function automatic logic src1_signed(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic src2_signed(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one shared (W+1)-bit add (multiply) or trial-subtract (restoring divide) step
module mdu_iter_step #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W:0]   i_part,
  input  logic [W-1:0] i_opnd,
  output logic [W:0]   o_next,
  output logic         o_qbit
);
  logic [W:0] w_b;
  logic [W:0] w_sum;
  always_comb begin
    w_b = i_div ? ~{1'b0, i_opnd} : {1'b0, i_opnd};
    w_sum = i_part + w_b + {{W{1'b0}}, i_div};
    o_qbit = i_div & ~w_sum[W];
    o_next = (i_div & w_sum[W]) ? i_part : w_sum;
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide with valid/ready in and out, 32 steps plus sign fix
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_receive_valid,
  output logic            mdu_send_ready,
  input  logic [XLEN-1:0] src1_input,
  input  logic [XLEN-1:0] src2_input,
  input  logic [2:0]      mdu_op_input,
  input  logic [4:0]      rd_input,
  input  logic            mdu_flush,
  output logic            mdu_send_valid,
  input  logic            mdu_receive_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            mdu_busy
);
  localparam int CW = $clog2(XLEN);
  mdu_state_e        r_state;
  mdu_op_e           r_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_sign;
  logic              r_valid;
  mdu_op_e           w_op;
  logic              w_neg1, w_neg2, w_div0, w_ovf, w_div, w_q;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_hi, w_lo, w_opnd, w_qr, w_fin;
  logic [XLEN:0]     w_part, w_next;
  logic [2*XLEN-1:0] w_prod;
  always_comb begin
    w_op = mdu_op_e'(mdu_op_input);
    w_neg1 = src1_signed(w_op) && src1_input[XLEN-1];
    w_neg2 = src2_signed(w_op) && src2_input[XLEN-1];
    w_mag1 = w_neg1 ? -src1_input : src1_input;
    w_mag2 = w_neg2 ? -src2_input : src2_input;
    w_div0 = is_div(w_op) && src2_input == '0;
    w_ovf = (w_op == OP_DIV || w_op == OP_REM) && src1_input == OVF_Q && src2_input == '1;
    w_hi = r_acc[2*XLEN-1:XLEN];
    w_lo = r_acc[XLEN-1:0];
    w_div = is_div(r_op);
    // Divide shifts the next dividend bit into the remainder; multiply adds only on a set multiplier bit
    w_part = w_div ? {w_hi, w_lo[XLEN-1]} : {1'b0, w_hi};
    w_opnd = (w_div || w_lo[0]) ? r_opnd : '0;
    w_prod = r_sign ? -r_acc : r_acc;
    w_qr = r_op[1] ? w_hi : w_lo;
    w_fin = w_div ? (r_sign ? -w_qr : w_qr)
          : (r_op == OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  end
  mdu_iter_step #(.W(XLEN)) u_step (
    .i_div (w_div),
    .i_part(w_part),
    .i_opnd(w_opnd),
    .o_next(w_next),
    .o_qbit(w_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op <= OP_MUL;
      r_rd <= '0;
      r_result <= '0;
      r_opnd <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_sign <= 1'b0;
      r_valid <= 1'b0;
    end else if (mdu_flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (mdu_receive_valid) begin
          r_op <= w_op;
          r_rd <= rd_input;
          r_sign <= w_neg1 ^ (w_neg2 && w_op != OP_REM);
          r_acc <= {{XLEN{1'b0}}, is_div(w_op) ? w_mag1 : w_mag2};
          r_opnd <= is_div(w_op) ? w_mag2 : w_mag1;
          r_cnt <= '0;
          if (w_div0 || w_ovf) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_result <= w_div0 ? (w_op[1] ? src1_input : DIV_ZERO_Q) : (w_op[1] ? '0 : OVF_Q);
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_div ? {w_next[XLEN-1:0], w_lo[XLEN-2:0], w_q} : {w_next, w_lo[XLEN-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) r_state <= SIGN;
        end
        SIGN: begin
          r_result <= w_fin;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (mdu_receive_ready) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
  assign mdu_send_ready = r_state == IDLE;
  assign mdu_busy = r_state != IDLE;
  assign mdu_send_valid = r_valid;
  assign result = r_result;
  assign rd = r_rd;
endmodule
